// File: rtl/tl_arbiter_if.sv
// Handshake bundle between tl_arbiter, its four source FIFOs and the downstream FIFO.
// master: the arbiter side; slave: the FIFO/environment side.
interface tl_arbiter_if;
  logic [3:0]  empty_in;
  logic [11:0] data_in0;
  logic [11:0] data_in1;
  logic [11:0] data_in2;
  logic [11:0] data_in3;
  logic        almost_full_in;
  logic [3:0]  pop;
  logic        push;
  logic [11:0] data_out;
  logic [3:0]  state;
  logic [1:0]  active_src;

  modport master (
    input  empty_in, data_in0, data_in1, data_in2, data_in3, almost_full_in,
    output pop, push, data_out, state, active_src
  );

  modport slave (
    output empty_in, data_in0, data_in1, data_in2, data_in3, almost_full_in,
    input  pop, push, data_out, state, active_src
  );
endinterface

// File: rtl/tl_arbiter.sv
// Four-source FIFO merge arbiter: round-robin by default, fixed priority 0>1>2>3 when
// TL_ARB_STRICT_PRIO_EN is defined. Pop in cycle N yields a registered push in cycle N+2.
module tl_arbiter (
  input  logic         clk,
  input  logic         reset,
  tl_arbiter_if.master bus
);

  typedef enum logic [3:0] {
    StReset  = 4'b0001,
    StInit   = 4'b0010,
    StIdle   = 4'b0100,
    StActive = 4'b1000
  } state_e;

  state_e      state_q, state_d;
  logic        any_ready;
  logic        grant_vld;
  logic [1:0]  grant_idx;
  logic        pop_en;
  logic        inflight_q;
  logic [1:0]  inflight_src_q;
  logic        push_q;
  logic [11:0] data_q;
  logic [11:0] sel_data;
  logic [1:0]  active_src_q;

  assign any_ready = ~&bus.empty_in;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StReset;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:  state_d = StInit;
      StInit:   state_d = StIdle;
      StIdle:   if (any_ready && !bus.almost_full_in) state_d = StActive;
      StActive: if (!any_ready || bus.almost_full_in) state_d = StIdle;
      default:  state_d = StReset;
    endcase
  end

`ifdef TL_ARB_STRICT_PRIO_EN
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bus.empty_in[i]) begin
        grant_vld = 1'b1;
        grant_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr_q;
  logic [1:0] cand;

  // Scan downward so the candidate closest to ptr_q is the last (winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    cand      = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (!bus.empty_in[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ptr_q <= 2'd0;
    else if (pop_en) ptr_q <= grant_idx + 2'd1;
  end
`endif

  always_comb begin
    pop_en    = (state_q == StActive) && !bus.almost_full_in && grant_vld;
    bus.pop   = pop_en ? (4'(1) << grant_idx) : 4'b0000;
    bus.state = state_q;
  end

  always_comb begin
    sel_data = bus.data_in0;
    unique case (inflight_src_q)
      2'd0: sel_data = bus.data_in0;
      2'd1: sel_data = bus.data_in1;
      2'd2: sel_data = bus.data_in2;
      2'd3: sel_data = bus.data_in3;
      default: sel_data = bus.data_in0;
    endcase
  end

  // Source read data arrives one cycle after the pop; capture it then and push next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q     <= 1'b0;
      inflight_src_q <= 2'd0;
      push_q         <= 1'b0;
      data_q         <= 12'h000;
      active_src_q   <= 2'd0;
    end else begin
      inflight_q <= pop_en;
      push_q     <= inflight_q;
      if (pop_en) begin
        inflight_src_q <= grant_idx;
        active_src_q   <= grant_idx;
      end
      if (inflight_q) data_q <= sel_data;
    end
  end

  assign bus.push       = push_q;
  assign bus.data_out   = data_q;
  assign bus.active_src = active_src_q;

endmodule
